// File: rtl/barrel_thread_sched.sv
// Round-robin barrel thread scheduler with per-thread PC file.
// Issues one thread slot per cycle in strict rotation and carries the slot tid to decode and writeback.
module barrel_thread_sched #(
   parameter int unsigned             NUM_THREADS = 8,
   parameter int unsigned             DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0]   RESET_PC    = '0,
   parameter int unsigned             WB_LATENCY  = 3,
   localparam int unsigned            TID_W       = $clog2(NUM_THREADS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_THREADS-1:0]  thread_en,
   input  logic                    redirect_valid,
   input  logic [TID_W-1:0]        redirect_tid,
   input  logic [DATA_WIDTH-1:0]   redirect_pc,
   input  logic                    halt_valid,
   input  logic [TID_W-1:0]        halt_tid,
   output logic                    fetch_valid,
   output logic [TID_W-1:0]        fetch_tid,
   output logic [DATA_WIDTH-1:0]   fetch_pc,
   output logic [TID_W-1:0]        tid_read,
   output logic                    read_valid,
   output logic [TID_W-1:0]        tid_write,
   output logic                    wb_valid,
   output logic [NUM_THREADS-1:0]  active
);

   logic [DATA_WIDTH-1:0] pc_q [NUM_THREADS];
   logic [DATA_WIDTH-1:0] pc_d [NUM_THREADS];
   logic [TID_W-1:0]      tid_pipe [WB_LATENCY];
   logic [WB_LATENCY-1:0] valid_pipe;

   logic [DATA_WIDTH-1:0] redirect_pc_al;
   logic [DATA_WIDTH-1:0] pc_inc;
   logic                  redirect_hit;
   logic                  halt_hit;
   logic                  unused_redirect_lsbs;

   assign redirect_pc_al       = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign redirect_hit = redirect_valid && (redirect_tid == fetch_tid);
   assign halt_hit     = halt_valid && (halt_tid == fetch_tid);

   assign fetch_valid = active[fetch_tid] & thread_en[fetch_tid] & ~halt_hit;
   // A redirect for the thread in its own slot is bypassed straight to instruction memory.
   assign fetch_pc    = redirect_hit ? redirect_pc_al : pc_q[fetch_tid];
   assign pc_inc      = fetch_pc + DATA_WIDTH'(4);

   // NOTE: every pc_d entry is given its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      for (int i = 0; i < NUM_THREADS; i++) begin
         pc_d[i] = pc_q[i];
         if (TID_W'(i) == fetch_tid) begin
            if (fetch_valid)
               pc_d[i] = pc_inc;
            else if (redirect_hit)
               pc_d[i] = redirect_pc_al;
         end else if (redirect_valid && (redirect_tid == TID_W'(i))) begin
            pc_d[i] = redirect_pc_al;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_tid  <= '0;
         active     <= '1;
         valid_pipe <= '0;
         // NOTE: the PC file is reset because every thread must start at RESET_PC.
         for (int i = 0; i < NUM_THREADS; i++)
            pc_q[i] <= RESET_PC;
         for (int k = 0; k < WB_LATENCY; k++)
            tid_pipe[k] <= '0;
      end else begin
         fetch_tid <= fetch_tid + 1'b1;
         for (int i = 0; i < NUM_THREADS; i++)
            pc_q[i] <= pc_d[i];
         if (halt_valid)
            active[halt_tid] <= 1'b0;
         tid_pipe[0]   <= fetch_tid;
         valid_pipe[0] <= fetch_valid;
         for (int k = 1; k < WB_LATENCY; k++) begin
            tid_pipe[k]   <= tid_pipe[k-1];
            valid_pipe[k] <= valid_pipe[k-1];
         end
      end
   end

   assign tid_read   = tid_pipe[0];
   assign read_valid = valid_pipe[0];
   assign tid_write  = tid_pipe[WB_LATENCY-1];
   assign wb_valid   = valid_pipe[WB_LATENCY-1];

endmodule
